// File: rtl/qeciphy_pkg.sv
// Shared QECIPHY definitions: frame alignment word, frame geometry and
// the receive alignment state/position types.
package qeciphy_pkg;

  // Frame alignment word inserted at the start of every frame.
  localparam logic [63:0] FAW_PATTERN = 64'hF628_F628_0A5C_3E91;

  // Each CRC group carries 6 data words followed by 1 validation word.
  localparam int DATA_WORDS_PER_GROUP = 6;
  localparam int GROUP_LEN            = DATA_WORDS_PER_GROUP + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_align_state_e;

  // Position of a word inside its group (0-5 data, 6 validation packet).
  typedef logic [2:0] word_pos_t;

  localparam word_pos_t LAST_WORD_POS = word_pos_t'(GROUP_LEN - 1);

  function automatic logic is_faw(input logic [63:0] word);
    return word == FAW_PATTERN;
  endfunction

endpackage

// File: rtl/qeciphy_rx_boundary_gen.sv
// Receive frame aligner: hunts for the FAW, verifies its spacing, then
// marks FAW and validation-packet slots on a one-cycle-delayed data path.
module qeciphy_rx_boundary_gen
  import qeciphy_pkg::*;
#(
  parameter int GROUPS_PER_FRAME = 64,
  parameter int LOCK_COUNT       = 3,
  parameter int MISS_LIMIT       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [63:0] tdata_i,
  output logic [63:0] tdata_o,
  output logic        faw_boundary_o,
  output logic        crc_boundary_o,
  output logic        locked_o,
  output logic        lock_lost_o
);

  localparam int GRP_W  = (GROUPS_PER_FRAME > 1) ? $clog2(GROUPS_PER_FRAME) : 1;
  localparam int OK_W   = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [GRP_W-1:0]  LAST_GROUP = GRP_W'(GROUPS_PER_FRAME - 1);
  localparam logic [OK_W-1:0]   OK_TARGET  = OK_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MISS_LIMIT);

  rx_align_state_e   state_q, state_d;
  logic              faw_slot_q, faw_slot_d;   // current tdata_i is the FAW slot
  logic [GRP_W-1:0]  group_cnt_q, group_cnt_d;
  word_pos_t         word_pos_q, word_pos_d;
  logic [OK_W-1:0]   ok_cnt_q, ok_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              lost_d;

  logic              locked_d, faw_bnd_d, crc_bnd_d;
  logic              faw_ok;

  assign faw_ok = is_faw(tdata_i);

  // Next-state, position tracking and lock/miss accounting.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned
    // (which would infer a latch).
    state_d     = state_q;
    faw_slot_d  = faw_slot_q;
    group_cnt_d = group_cnt_q;
    word_pos_d  = word_pos_q;
    ok_cnt_d    = ok_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lost_d      = 1'b0;

    // Free-running slot advance while aligned; HUNT re-seeds it below.
    if (faw_slot_q) begin
      faw_slot_d  = 1'b0;
      group_cnt_d = '0;
      word_pos_d  = '0;
    end else if (word_pos_q == LAST_WORD_POS) begin
      word_pos_d = '0;
      if (group_cnt_q == LAST_GROUP) begin
        group_cnt_d = '0;
        faw_slot_d  = 1'b1;
      end else begin
        group_cnt_d = group_cnt_q + 1'b1;
      end
    end else begin
      word_pos_d = word_pos_q + 1'b1;
    end

    case (state_q)
      HUNT: begin
        faw_slot_d  = 1'b0;
        group_cnt_d = '0;
        word_pos_d  = '0;
        miss_cnt_d  = '0;
        ok_cnt_d    = '0;
        if (faw_ok) begin
          state_d  = VERIFY;
          ok_cnt_d = OK_W'(1);
        end
      end
      VERIFY: begin
        if (faw_slot_q) begin
          if (!faw_ok) begin
            state_d = HUNT;
          end else if (ok_cnt_q + 1'b1 == OK_TARGET) begin
            state_d  = LOCKED;
            ok_cnt_d = '0;
          end else begin
            ok_cnt_d = ok_cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (faw_slot_q) begin
          if (faw_ok) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q + 1'b1 == MISS_MAX) begin
            state_d = HUNT;
            lost_d  = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Leaving alignment (or a disabled link) always restarts from a clean slate.
    if (!enable_i) begin
      state_d = HUNT;
      lost_d  = 1'b0;
    end
    if (state_d == HUNT) begin
      faw_slot_d  = 1'b0;
      group_cnt_d = '0;
      word_pos_d  = '0;
      ok_cnt_d    = '0;
      miss_cnt_d  = '0;
    end
  end

  // Output decode describes the word being registered this cycle.
  always_comb begin
    locked_d  = (state_d == LOCKED);
    faw_bnd_d = locked_d && faw_slot_q;
    crc_bnd_d = locked_d && !faw_slot_q && (word_pos_q == LAST_WORD_POS);
  end

  // State, counters and the registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= HUNT;
      faw_slot_q     <= 1'b0;
      group_cnt_q    <= '0;
      word_pos_q     <= '0;
      ok_cnt_q       <= '0;
      miss_cnt_q     <= '0;
      tdata_o        <= '0;
      faw_boundary_o <= 1'b0;
      crc_boundary_o <= 1'b0;
      locked_o       <= 1'b0;
      lock_lost_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      faw_slot_q     <= faw_slot_d;
      group_cnt_q    <= group_cnt_d;
      word_pos_q     <= word_pos_d;
      ok_cnt_q       <= ok_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      tdata_o        <= tdata_i;
      faw_boundary_o <= faw_bnd_d;
      crc_boundary_o <= crc_bnd_d;
      locked_o       <= locked_d;
      lock_lost_o    <= lost_d;
    end
  end

endmodule

// File: tb/tb_qeciphy_rx_boundary_gen.sv
// Randomized self-checking bench for qeciphy_rx_boundary_gen with a
// frame-offset reference model (GROUPS_PER_FRAME=2, frame length 15).
module tb_qeciphy_rx_boundary_gen;
  import qeciphy_pkg::FAW_PATTERN;

  localparam int GPF       = 2;
  localparam int LOCK_CNT  = 3;
  localparam int MISS_LIM  = 4;
  localparam int GRP_LEN   = 7;
  localparam int FRAME_LEN = 1 + GRP_LEN * GPF;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic [63:0] tdata_i = '0;
  logic [63:0] tdata_o;
  logic        faw_boundary_o, crc_boundary_o, locked_o, lock_lost_o;

  qeciphy_rx_boundary_gen #(
    .GROUPS_PER_FRAME(GPF),
    .LOCK_COUNT      (LOCK_CNT),
    .MISS_LIMIT      (MISS_LIM)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .tdata_i       (tdata_i),
    .tdata_o       (tdata_o),
    .faw_boundary_o(faw_boundary_o),
    .crc_boundary_o(crc_boundary_o),
    .locked_o      (locked_o),
    .lock_lost_o   (lock_lost_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=hunt 1=verify 2=locked; slots derived from
  // the offset of the current word relative to the first FAW seen.
  int          m_mode = 0;
  int          m_ok = 0;
  int          m_miss = 0;
  longint      m_anchor = 0;
  longint      cyc = 0;
  int          exp_lost_total = 0;
  int          obs_lost_total = 0;
  logic [63:0] exp_tdata;
  logic        exp_faw, exp_crc, exp_locked, exp_lost;

  task automatic model_step(input logic en, input logic [63:0] d);
    int off;
    bit f_slot, c_slot;
    f_slot = 0; c_slot = 0;
    exp_tdata = d;
    exp_lost  = 1'b0;
    if (!en) begin
      m_mode = 0; m_ok = 0; m_miss = 0;
    end else if (m_mode == 0) begin
      if (d == FAW_PATTERN) begin
        m_mode = 1; m_ok = 1; m_miss = 0; m_anchor = cyc;
      end
    end else begin
      off    = int'((cyc - m_anchor) % FRAME_LEN);
      f_slot = (off == 0);
      c_slot = (off != 0) && (off % GRP_LEN == 0);
      if (f_slot) begin
        if (m_mode == 1) begin
          if (d == FAW_PATTERN) begin
            m_ok++;
            if (m_ok == LOCK_CNT) m_mode = 2;
          end else begin
            m_mode = 0;
          end
        end else begin
          if (d == FAW_PATTERN) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == MISS_LIM) begin
              m_mode = 0; m_miss = 0; exp_lost = 1'b1; exp_lost_total++;
            end
          end
        end
      end
    end
    exp_locked = (m_mode == 2);
    exp_faw    = exp_locked && f_slot;
    exp_crc    = exp_locked && c_slot;
  endtask

  task automatic step(input logic en, input logic [63:0] d);
    enable_i = en;
    tdata_i  = d;
    model_step(en, d);
    @(posedge clk_i);
    #1;
    if (lock_lost_o) obs_lost_total++;
    check("tdata_o", tdata_o, exp_tdata);
    check("faw_boundary_o", 64'(faw_boundary_o), 64'(exp_faw));
    check("crc_boundary_o", 64'(crc_boundary_o), 64'(exp_crc));
    check("locked_o", 64'(locked_o), 64'(exp_locked));
    check("lock_lost_o", 64'(lock_lost_o), 64'(exp_lost));
    check("boundary_exclusive", 64'(faw_boundary_o & crc_boundary_o), 64'd0);
    cyc++;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w == FAW_PATTERN) w = ~w;
    return w;
  endfunction

  function automatic logic [63:0] bad_faw();
    logic [63:0] one;
    one = 64'd1;
    return FAW_PATTERN ^ (one << $urandom_range(63, 0));
  endfunction

  // One frame: FAW slot (good or corrupted) then GPF groups of 7 words.
  task automatic send_frame(input bit bad, input bit faw_at_pos3);
    logic [63:0] d;
    step(1'b1, bad ? bad_faw() : FAW_PATTERN);
    for (int g = 0; g < GPF; g++) begin
      for (int p = 0; p < GRP_LEN; p++) begin
        d = (faw_at_pos3 && p == 3) ? FAW_PATTERN : rand_word();
        step(1'b1, d);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdata"}, tdata_o, 64'd0);
    check({tag, "_flags"}, 64'({faw_boundary_o, crc_boundary_o, locked_o, lock_lost_o}), 64'd0);
  endtask

  initial begin
    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst_i = 1'b1;
    #2 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk_i);
    #1 check_reset_outputs("reset_held");
    rst_i = 1'b0;
    m_mode = 0; m_ok = 0; m_miss = 0;

    // Idle link words, then three well-formed frames achieve lock.
    for (int i = 0; i < 5; i++) step(1'b1, rand_word());
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0);
    check("lock_after_3_faw", 64'(m_mode == 2 && locked_o), 64'd1);
    send_frame(1'b0, 1'b0);

    // 3 bad, 1 good, 3 bad: lock survives.
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0);
    send_frame(1'b0, 1'b0);
    for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0);
    check("no_loss_interleaved", 64'(locked_o), 64'd1);
    send_frame(1'b0, 1'b0);

    // FAW pattern in a data slot while locked is ignored.
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b1);

    // Four consecutive bad FAWs lose lock with a single pulse.
    for (int f = 0; f < 4; f++) send_frame(1'b1, 1'b0);
    check("lost_pulse_count", 64'(obs_lost_total), 64'(exp_lost_total));
    check("unlocked_after_loss", 64'(locked_o), 64'd0);

    // Re-lock, then a one-cycle enable drop mid-frame.
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, rand_word());
    step(1'b0, rand_word());
    check("enable_drop_unlock", 64'(locked_o), 64'd0);
    for (int i = 0; i < FRAME_LEN - 5; i++) step(1'b1, rand_word());
    for (int f = 0; f < 2; f++) send_frame(1'b0, 1'b0);
    check("relock_needs_3", 64'(locked_o), 64'd0);
    send_frame(1'b0, 1'b0);

    // VERIFY abort: two good FAWs, corrupted third.
    step(1'b0, rand_word());
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    send_frame(1'b1, 1'b0);
    check("verify_abort_unlocked", 64'(locked_o), 64'd0);

    // Enable drop coincident with lock completion wins.
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    step(1'b0, FAW_PATTERN);
    check("enable_priority_lock", 64'(locked_o), 64'd0);

    // Randomized frames with corrupted FAWs and occasional enable drops.
    for (int f = 0; f < 40; f++) begin
      step(1'b1, ($urandom_range(3, 0) == 0) ? bad_faw() : FAW_PATTERN);
      for (int i = 1; i < FRAME_LEN; i++)
        step(($urandom_range(59, 0) != 0), ($urandom_range(15, 0) == 0) ? FAW_PATTERN : rand_word());
    end

    // Reset mid-lock drops outputs at once, with no loss pulse.
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("locked_before_reset", 64'(locked_o), 64'd1);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("reset_mid_lock");
    m_mode = 0; m_ok = 0; m_miss = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(1'b0, 1'b0);
    check("relock_after_reset", 64'(locked_o), 64'd1);
    check("lost_pulse_total", 64'(obs_lost_total), 64'(exp_lost_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qeciphy_rx_boundary_gen.md
QECIPHY_RX_BOUNDARY_GEN -- requirements
Module: qeciphy_rx_boundary_gen

Interface
REQ-001 Parameter GROUPS_PER_FRAME, 64, number of CRC groups between FAW words; frame length = 1 + 7*GROUPS_PER_FRAME words.
REQ-002 Parameter LOCK_COUNT, 3, consecutive correctly-spaced FAWs needed to declare lock.
REQ-003 Parameter MISS_LIMIT, 4, consecutive invalid FAWs in LOCKED that cause loss of lock.
REQ-004 clk_i  input  1  single clock for the whole block.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 enable_i  input  1  link ready; low forces HUNT.
REQ-007 tdata_i  input  64  aligned receive word, one per cycle.
REQ-008 tdata_o  output  64  tdata_i delayed one cycle.
REQ-009 faw_boundary_o  output  1  tdata_o is a FAW slot; feeds the rx monitor's faw_boundary_i.
REQ-010 crc_boundary_o  output  1  tdata_o is a validation/CRC packet slot; feeds the rx monitor's crc_boundary_i.
REQ-011 locked_o  output  1  frame lock held; drives the rx monitor's enable_i.
REQ-012 lock_lost_o  output  1  one-cycle pulse when lock is lost through FAW misses.

Function
REQ-013 Frame layout SHALL be: FAW word, then GROUPS_PER_FRAME groups; each group is 6 data words (pos 0-5) followed by 1 validation packet word (pos 6).
REQ-014 Position tracking SHALL use word_pos (0-6) and group_cnt (0 to GROUPS_PER_FRAME-1), plus a FAW-slot flag; counters wrap pos 6 -> 0 and the last group -> FAW slot.
REQ-015 FSM states SHALL be HUNT, VERIFY and LOCKED.
REQ-016 HUNT: is_faw(tdata_i) SHALL move to VERIFY with ok_cnt=1, and the next word SHALL be group 0, pos 0.
REQ-017 VERIFY, expected FAW slot, valid FAW: ok_cnt++; on reaching LOCK_COUNT -> LOCKED, else stay.
REQ-018 VERIFY, expected FAW slot, invalid FAW: SHALL return to HUNT; non-FAW slots are not examined.
REQ-019 LOCKED, expected FAW slot, valid FAW: SHALL clear miss_cnt.
REQ-020 LOCKED, expected FAW slot, invalid FAW: miss_cnt++; on reaching MISS_LIMIT -> HUNT, with lock_lost_o=1 for exactly one cycle.
REQ-021 All outputs SHALL be registered with latency 1; faw_boundary_o, crc_boundary_o and locked_o SHALL align with the tdata_o word they describe.
REQ-022 The FAW word that completes lock SHALL be emitted with locked_o=1 and faw_boundary_o=1 in the same cycle.
REQ-023 The FAW slot word that causes loss of lock SHALL be emitted with locked_o=0 and faw_boundary_o=0.
REQ-024 faw_boundary_o and crc_boundary_o SHALL be 0 whenever locked_o=0, and SHALL never both be 1.
REQ-025 In LOCKED, boundaries SHALL follow slot position regardless of word content; content checking belongs to the rx monitor.
REQ-026 enable_i low SHALL clear state to HUNT and all counters; locked_o and boundaries go 0 next cycle; no lock_lost_o pulse.
REQ-027 enable_i low SHALL take priority over a simultaneous lock completion or miss-limit event.
REQ-028 A FAW pattern inside a data slot while LOCKED SHALL be ignored.

Reset
REQ-029 On rst_i, state=HUNT, all counters=0, and all outputs SHALL be 0 (tdata_o=64'h0) immediately, independent of clk_i.
REQ-030 Reset release SHALL resume hunting on the first clock edge after release.
REQ-031 Reset mid-LOCKED SHALL drop locked_o at once without asserting lock_lost_o.

Structure
REQ-032 DATA_WORDS_PER_GROUP=6, GROUP_LEN=7 and the frame-position types SHALL live in qeciphy_pkg, reusing its existing is_faw().
REQ-033 No sub-module SHALL be used; counters and the FSM stay in one module.

Verification (GROUPS_PER_FRAME=2, frame length 15)
REQ-034 Reset held, then 3 well-formed frames -> locked_o rises with the 3rd FAW on tdata_o; faw_boundary_o every 15 cycles; crc_boundary_o at offsets 7 and 14.
REQ-035 Lock held, FAW corrupted in 4 consecutive frames -> lock_lost_o single pulse at the 4th bad slot; locked_o=0 and both boundaries 0 afterwards.
REQ-036 Lock held, 3 bad FAWs then 1 good FAW then 3 bad FAWs -> lock is never lost.
REQ-037 In VERIFY after 2 good FAWs, the 3rd FAW slot is corrupted -> return to HUNT; locked_o stays 0.
REQ-038 Lock held, FAW pattern injected at pos 3 -> no effect on outputs.
REQ-039 Lock held, enable_i low for 1 cycle -> locked_o=0 next cycle, no lock_lost_o; re-lock needs 3 more FAWs.
